// File: rtl/fft_capture_ctrl.sv
// Capture controller: frames FRAME_LEN samples from din into an AXI-stream FFT port and waits for fft_done.
// Optional WAIT_DONE watchdog enabled by defining FFT_CAPTURE_TIMEOUT_EN.
module fft_capture_ctrl #(
  parameter int unsigned N         = 16,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned HOLDOFF   = 100,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         trig,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  input  logic         fft_done,
  output logic         busy,
  output logic [15:0]  frame_cnt,
  output logic         err_timeout
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  if (N < 1 || FRAME_LEN < 2 || FRAME_LEN > 65535 || HOLDOFF < 1 || TIMEOUT < 1) begin : g_param_err
    $error("fft_capture_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_HOLDOFF   = 3'd0,
    S_ARM       = 3'd1,
    S_CAPTURE   = 3'd2,
    S_DRAIN     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HO_W-1:0]   holdoff_cnt;
  logic [CNT_W-1:0]  sample_cnt;
  logic              holdoff_done;
  logic              last_sample;
  logic              acc_in;
  logic              acc_out;
  logic              timeout_hit;

  assign holdoff_done = (holdoff_cnt == HO_W'(HOLDOFF - 1));
  assign last_sample  = (sample_cnt == CNT_W'(FRAME_LEN - 1));
  assign acc_in       = din_valid && din_ready;
  assign acc_out      = m_tvalid && m_tready;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_HOLDOFF;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLDOFF:   if (holdoff_done)            state_nxt = S_ARM;
      S_ARM:       if (trig)                    state_nxt = S_CAPTURE;
      S_CAPTURE:   if (acc_in && last_sample)   state_nxt = S_DRAIN;
      S_DRAIN:     if (acc_out)                 state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (fft_done || timeout_hit) state_nxt = S_ARM;
      default:                                  state_nxt = S_HOLDOFF;
    endcase
  end

  // Output decode; din_ready looks through the output register for full throughput
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      S_ARM:     busy      = 1'b0;
      S_CAPTURE: din_ready = !m_tvalid || m_tready;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      holdoff_cnt <= '0;
    end else if (state == S_HOLDOFF && !holdoff_done) begin
      holdoff_cnt <= holdoff_cnt + HO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample_cnt <= '0;
    end else if (state == S_ARM && trig) begin
      sample_cnt <= '0;
    end else if (acc_in) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

  // Single-entry output register: a new load may coincide with the previous beat draining
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (acc_in) begin
      m_tdata  <= din;
      m_tvalid <= 1'b1;
      m_tlast  <= last_sample;
    end else if (acc_out) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frame_cnt <= '0;
    end else if (state == S_WAIT_DONE && fft_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef FFT_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt;

  // fft_done arriving on the final cycle still counts as a completed frame
  assign timeout_hit = (state == S_WAIT_DONE) && !fft_done && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT_DONE)  to_cnt <= '0;
      else if (!timeout_hit)     to_cnt <= to_cnt + TO_W'(1);
      if (timeout_hit)           err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_capture_ctrl.sv
// Directed bench for fft_capture_ctrl (FRAME_LEN=8, HOLDOFF=100, TIMEOUT=16); timeout path checked when FFT_CAPTURE_TIMEOUT_EN is defined.
module tb_fft_capture_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned FL = 8;
  localparam int unsigned HO = 100;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         trig = 1'b0;
  logic [N-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [N-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         fft_done = 1'b0;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic         err_timeout;

  int total = 0;
  int bad   = 0;
  int exp_fc = 0;

  fft_capture_ctrl #(.N(N), .FRAME_LEN(FL), .HOLDOFF(HO), .TIMEOUT(TO)) dut (
    .clk(clk), .nreset(nreset), .trig(trig), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .fft_done(fft_done), .busy(busy), .frame_cnt(frame_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      32'(busy),        32'd1);
    chk({tag, "_din_ready"}, 32'(din_ready),   32'd0);
    chk({tag, "_tvalid"},    32'(m_tvalid),    32'd0);
    chk({tag, "_tlast"},     32'(m_tlast),     32'd0);
    chk({tag, "_tdata"},     32'(m_tdata),     32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt),   32'd0);
    chk({tag, "_err"},       32'(err_timeout), 32'd0);
  endtask

  // Full-throughput frame from CAPTURE through to WAIT_DONE entry
  task automatic full_frame(input int base);
    m_tready  = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < int'(FL); i++) begin
      din = N'(base + i);
      tick();
      chk("ff_tdata",  32'(m_tdata),  32'(base + i));
      chk("ff_tvalid", 32'(m_tvalid), 32'd1);
      chk("ff_tlast",  32'(m_tlast),  32'(i == int'(FL) - 1));
    end
    chk("drain_din_ready", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    tick();
    chk("wait_tvalid", 32'(m_tvalid), 32'd0);
    chk("wait_tlast",  32'(m_tlast),  32'd0);
    chk("wait_busy",   32'(busy),     32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_n;
    int out_n;
    logic acc_in;
    logic acc_out;
    logic stall;

    #12;
    chk_reset_vals("por");
    tick();
    nreset = 1'b1;

    // Holdoff: trig at cycle 50 ignored, ARM after 100 cycles, trig at 120 captures
    for (int c = 1; c <= 120; c++) begin
      trig = (c == 50 || c == 120);
      tick();
      trig = 1'b0;
      if (c == 50)  chk("ho_trig50_busy", 32'(busy), 32'd1);
      if (c == 99)  chk("ho_c99_busy",    32'(busy), 32'd1);
      if (c == 100) chk("ho_c100_busy",   32'(busy), 32'd0);
      if (c == 100) chk("ho_c100_ready",  32'(din_ready), 32'd0);
      if (c == 119) chk("arm_c119_busy",  32'(busy), 32'd0);
    end
    chk("cap_busy",  32'(busy),      32'd1);
    chk("cap_ready", 32'(din_ready), 32'd1);

    full_frame(0);

    // trig during WAIT_DONE must be dropped
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("wd_trig_busy", 32'(busy), 32'd1);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    exp_fc = 1;
    chk("done_fc",   32'(frame_cnt), 32'(exp_fc));
    chk("done_busy", 32'(busy),      32'd0);

    // fft_done in ARM ignored; earlier trig not queued
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("arm_done_fc",   32'(frame_cnt), 32'(exp_fc));
    chk("arm_done_busy", 32'(busy),      32'd0);

    // Backpressure frame: m_tready toggles 1,0,1,0
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("bp_ready0", 32'(din_ready), 32'd1);
    in_n  = 0;
    out_n = 0;
    for (int cyc = 0; cyc < 40 && out_n < int'(FL); cyc++) begin
      din       = N'(10 + in_n);
      din_valid = (in_n < int'(FL));
      m_tready  = (cyc % 2 == 0);
      #1;
      acc_in  = din_valid && din_ready;
      acc_out = m_tvalid && m_tready;
      stall   = m_tvalid && !m_tready;
      if (acc_out) begin
        chk("bp_tdata", 32'(m_tdata), 32'(10 + out_n));
        chk("bp_tlast", 32'(m_tlast), 32'(out_n == int'(FL) - 1));
        out_n++;
      end
      tick();
      if (stall) begin
        chk("bp_hold_tdata",  32'(m_tdata),  32'(10 + out_n));
        chk("bp_hold_tvalid", 32'(m_tvalid), 32'd1);
      end
      if (acc_in) in_n++;
    end
    din_valid = 1'b0;
    m_tready  = 1'b1;
    chk("bp_in_count",  32'(in_n),     32'(FL));
    chk("bp_out_count", 32'(out_n),    32'(FL));
    chk("bp_wd_tvalid", 32'(m_tvalid), 32'd0);
    chk("bp_wd_busy",   32'(busy),     32'd1);

`ifdef FFT_CAPTURE_TIMEOUT_EN
    for (int k = 1; k <= int'(TO); k++) begin
      tick();
      if (k == int'(TO) - 1) chk("to_pre_err",  32'(err_timeout), 32'd0);
      if (k == int'(TO) - 1) chk("to_pre_busy", 32'(busy),        32'd1);
    end
    chk("to_err",  32'(err_timeout), 32'd1);
    chk("to_busy", 32'(busy),        32'd0);
    chk("to_fc",   32'(frame_cnt),   32'(exp_fc));
`else
    repeat (20) tick();
    chk("nto_busy", 32'(busy),        32'd1);
    chk("nto_err",  32'(err_timeout), 32'd0);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    exp_fc = 2;
    chk("nto_fc",   32'(frame_cnt), 32'(exp_fc));
    chk("nto_arm",  32'(busy),      32'd0);
`endif

    // Reset after 4 samples of a frame, then a clean frame after holdoff
    trig = 1'b1;
    tick();
    trig = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = N'(30 + i);
      tick();
    end
    chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    #3;
    nreset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    din_valid = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    for (int c = 1; c <= int'(HO); c++) begin
      tick();
      if (c == int'(HO) - 1) chk("rst_ho_busy", 32'(busy), 32'd1);
    end
    chk("rst_arm_busy", 32'(busy), 32'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    full_frame(40);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("rst_fc", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_capture_ctrl.md
FFT_CAPTURE_CTRL -- requirements
Module: fft_capture_ctrl

Interface
REQ-001 Parameter N, default 16: sample width in bits.
REQ-002 Parameter FRAME_LEN, default 1024: samples per FFT frame; legal range 2..65535.
REQ-003 Parameter HOLDOFF, default 100: cycles after reset deassertion before triggers are honoured.
REQ-004 Parameter TIMEOUT, default 4096: maximum cycles in WAIT_DONE before abort; used only when FFT_CAPTURE_TIMEOUT_EN is defined.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 nreset  in  1  reset, asynchronous, active-low.
REQ-007 trig  in  1  one-cycle frame-start request from the upstream change detector.
REQ-008 din  in  N  sample data.
REQ-009 din_valid  in  1  din qualifier.
REQ-010 din_ready  out  1  sample accepted when din_valid && din_ready.
REQ-011 m_tdata  out  N  sample to the FFT core.
REQ-012 m_tvalid  out  1  m_tdata valid.
REQ-013 m_tready  in  1  FFT core accepts a beat when m_tvalid && m_tready.
REQ-014 m_tlast  out  1  marks the FRAME_LEN-th beat of a frame.
REQ-015 fft_done  in  1  one-cycle pulse from the FFT core: frame processed.
REQ-016 busy  out  1  high in every state except ARM.
REQ-017 frame_cnt  out  16  completed frames, wraps 65535->0.
REQ-018 err_timeout  out  1  sticky; set on WAIT_DONE timeout.

Function
REQ-019 The block SHALL implement states HOLDOFF, ARM, CAPTURE, DRAIN and WAIT_DONE.
REQ-020 HOLDOFF: count HOLDOFF cycles from reset release, then go to ARM; trig is ignored in HOLDOFF.
REQ-021 ARM: trig=1 -> CAPTURE next cycle and clear the sample counter; trig pulses in any other state are dropped (not queued).
REQ-022 CAPTURE: din_ready = !m_tvalid || m_tready; each accepted sample loads m_tdata, sets m_tvalid and increments the sample counter.
REQ-023 m_tvalid SHALL stay high and m_tdata/m_tlast stable until accepted by m_tready; the block SHALL never drop or duplicate a beat.
REQ-024 m_tlast SHALL be 1 on exactly the beat carrying sample FRAME_LEN-1 (zero-based) and 0 otherwise.
REQ-025 Accepting sample FRAME_LEN-1 -> DRAIN; din_ready=0 in DRAIN, ARM, HOLDOFF and WAIT_DONE.
REQ-026 DRAIN: on the cycle the last beat is accepted -> WAIT_DONE.
REQ-027 Simultaneous acceptance of an output beat and a new input sample in one cycle SHALL be supported (full throughput, one sample/cycle).
REQ-028 WAIT_DONE: fft_done=1 -> ARM next cycle and frame_cnt increments by 1.
REQ-029 fft_done in any state other than WAIT_DONE SHALL be ignored.
REQ-030 Sample counter SHALL be 16 bits; no other arithmetic wraps except frame_cnt.

Reset
REQ-031 nreset=0 SHALL asynchronously force state HOLDOFF, counters 0, m_tvalid=0, m_tlast=0, m_tdata=0, din_ready=0, frame_cnt=0, err_timeout=0, busy=1.
REQ-032 Reset mid-frame SHALL abandon the frame immediately; no m_tlast is emitted for it and frame_cnt does not increment.

Configuration
REQ-033 Macro FFT_CAPTURE_TIMEOUT_EN defined: WAIT_DONE counts cycles; reaching TIMEOUT without fft_done sets err_timeout and goes to ARM without incrementing frame_cnt.
REQ-034 Macro FFT_CAPTURE_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely; err_timeout is constant 0 and no timeout counter is built.

Verification
REQ-035 Reset release, trig at cycle 50 -> ignored, state remains HOLDOFF; trig at cycle 120 -> CAPTURE, busy stays 1.
REQ-036 FRAME_LEN=8, din_valid and m_tready held 1, din=0..7 -> m_tdata 0..7 on 8 consecutive cycles, m_tlast only with 7, then WAIT_DONE.
REQ-037 FRAME_LEN=8, m_tready toggling 1,0,1,0 -> every sample delivered once, in order, m_tdata stable while m_tready=0.
REQ-038 fft_done pulse in WAIT_DONE -> ARM next cycle, frame_cnt 0->1; fft_done pulse in ARM -> frame_cnt unchanged.
REQ-039 FFT_CAPTURE_TIMEOUT_EN defined, TIMEOUT=16, no fft_done -> err_timeout=1 after 16 cycles in WAIT_DONE, state ARM, frame_cnt unchanged.
REQ-040 nreset asserted after sample 3 of 8 -> all outputs at reset values asynchronously; next frame after HOLDOFF starts at sample index 0.
